// File: rtl/exp_diff_pipe_if.sv
// Handshake and data bundle between the exponent adders and the exponent-difference pipeline.
// The master side drives the transaction inputs and out_ready; the slave side is the pipeline.
interface exp_diff_pipe_if #(
    parameter int N_PROD = 6,
    parameter int EXP_W  = 8,
    parameter int SH_W   = 5
);
    logic                          in_valid;
    logic                          in_ready;
    logic [1:0]                    mode;
    logic [(N_PROD+1)*EXP_W-1:0]   exp_in;
    logic                          out_valid;
    logic                          out_ready;
    logic [EXP_W-1:0]              max_exp;
    logic [(N_PROD+1)*SH_W-1:0]    shift;
    logic [N_PROD:0]               lane_en;
    logic [N_PROD:0]               flush;
    logic [1:0]                    mode_out;

    modport master (
        output in_valid,
        output mode,
        output exp_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  max_exp,
        input  shift,
        input  lane_en,
        input  flush,
        input  mode_out
    );

    modport slave (
        input  in_valid,
        input  mode,
        input  exp_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output max_exp,
        output shift,
        output lane_en,
        output flush,
        output mode_out
    );
endinterface

// File: rtl/exp_diff_pipe.sv
// Two-stage exponent-difference generator: stage 1 masks lanes and finds the max exponent,
// stage 2 turns (max - exp) into saturated per-lane alignment shifts with flush flags.
module exp_diff_pipe #(
    parameter int N_PROD = 6,
    parameter int EXP_W  = 8,
    parameter int SH_W   = 5,
    parameter int MAX_SH = 24
) (
    input  logic               clk,
    input  logic               rst,
    exp_diff_pipe_if.slave     bus
);
    localparam int N_LANES = N_PROD + 1;
    localparam int C_LANE  = N_PROD;

    localparam logic [1:0] MODE_BF16 = 2'b00;
    localparam logic [1:0] MODE_P3   = 2'b01;
    localparam logic [1:0] MODE_RSVD = 2'b10;
    localparam logic [1:0] MODE_P6   = 2'b11;

    localparam logic [SH_W-1:0]  SH_SAT      = SH_W'(MAX_SH);
    localparam logic [31:0]      MAX_SH_U    = 32'(MAX_SH);
    localparam logic [EXP_W-1:0] NARROW_MASK = EXP_W'(4'hF);

    // Active lanes per mode; the C lane rides along in every defined mode.
    function automatic logic [N_PROD:0] lane_mask(input logic [1:0] m);
        logic [N_PROD:0] msk;
        msk = '0;
        case (m)
            MODE_BF16: begin
                msk[0]      = 1'b1;
                msk[C_LANE] = 1'b1;
            end
            MODE_P3: begin
                msk[2:0]    = 3'b111;
                msk[C_LANE] = 1'b1;
            end
            MODE_P6:   msk = '1;
            MODE_RSVD: msk = '0;
            default:   msk = '0;
        endcase
        return msk;
    endfunction

    function automatic logic [EXP_W-1:0] cond_exp(input logic [EXP_W-1:0] e,
                                                  input logic             narrow,
                                                  input logic             act);
        logic [EXP_W-1:0] r;
        if (!act) begin
            r = '0;
        end else if (narrow) begin
            r = e & NARROW_MASK;
        end else begin
            r = e;
        end
        return r;
    endfunction

    // Pairwise reduction: log2(N_LANES) levels of comparators rather than a serial chain.
    function automatic logic [EXP_W-1:0] max_tree(input logic [N_LANES-1:0][EXP_W-1:0] v_in);
        logic [N_LANES-1:0][EXP_W-1:0] v;
        v = v_in;
        for (int step = 1; step < N_LANES; step = step * 2) begin
            for (int i = 0; i + step < N_LANES; i = i + 2 * step) begin
                if (v[i+step] > v[i]) begin
                    v[i] = v[i+step];
                end else begin
                    v[i] = v[i];
                end
            end
        end
        return v[0];
    endfunction

    logic                          s1_valid_r;
    logic [N_LANES-1:0][EXP_W-1:0] s1_exp_r;
    logic [EXP_W-1:0]              s1_max_r;
    logic [N_PROD:0]               s1_mask_r;
    logic [1:0]                    s1_mode_r;

    logic                          out_valid_r;
    logic [EXP_W-1:0]              max_exp_r;
    logic [N_LANES*SH_W-1:0]       shift_r;
    logic [N_PROD:0]               lane_en_r;
    logic [N_PROD:0]               flush_r;
    logic [1:0]                    mode_out_r;

    logic                          s2_adv_s;
    logic                          s1_adv_s;
    logic                          accept_s;
    logic [N_PROD:0]               in_mask_s;
    logic                          narrow_s;
    logic [N_LANES-1:0][EXP_W-1:0] in_exp_s;
    logic [N_LANES-1:0][EXP_W-1:0] diff_s;
    logic [N_LANES*SH_W-1:0]       shift_s;
    logic [N_PROD:0]               flush_s;

    assign s2_adv_s     = !out_valid_r || bus.out_ready;
    assign s1_adv_s     = !s1_valid_r || s2_adv_s;
    assign accept_s     = bus.in_valid && s1_adv_s;
    assign bus.in_ready = s1_adv_s;

    // Lane masking and exponent conditioning ahead of the stage-1 registers.
    always_comb begin
        in_mask_s = lane_mask(bus.mode);
        narrow_s  = (bus.mode != MODE_BF16);
        in_exp_s  = '0;
        for (int i = 0; i < N_LANES; i++) begin
            in_exp_s[i] = cond_exp(bus.exp_in[i*EXP_W +: EXP_W], narrow_s, in_mask_s[i]);
        end
    end

    // Stage 1: capture conditioned exponents and their maximum on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_exp_r   <= '0;
            s1_max_r   <= '0;
            s1_mask_r  <= '0;
            s1_mode_r  <= 2'b00;
        end else if (s1_adv_s) begin
            s1_valid_r <= bus.in_valid;
            if (accept_s) begin
                s1_exp_r  <= in_exp_s;
                s1_max_r  <= max_tree(in_exp_s);
                s1_mask_r <= in_mask_s;
                s1_mode_r <= bus.mode;
            end
        end
    end

    // Saturating per-lane difference; max is over the same lanes, so diff never wraps.
    always_comb begin
        diff_s  = '0;
        shift_s = '0;
        flush_s = '0;
        for (int i = 0; i < N_LANES; i++) begin
            diff_s[i] = s1_max_r - s1_exp_r[i];
            if (!s1_mask_r[i]) begin
                shift_s[i*SH_W +: SH_W] = '0;
                flush_s[i]              = 1'b0;
            end else if (32'(diff_s[i]) > MAX_SH_U) begin
                shift_s[i*SH_W +: SH_W] = SH_SAT;
                flush_s[i]              = 1'b1;
            end else begin
                shift_s[i*SH_W +: SH_W] = SH_W'(diff_s[i]);
                flush_s[i]              = 1'b0;
            end
        end
    end

    // Stage 2: output registers, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            max_exp_r   <= '0;
            shift_r     <= '0;
            lane_en_r   <= '0;
            flush_r     <= '0;
            mode_out_r  <= 2'b00;
        end else if (s2_adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                max_exp_r  <= s1_max_r;
                shift_r    <= shift_s;
                lane_en_r  <= s1_mask_r;
                flush_r    <= flush_s;
                mode_out_r <= s1_mode_r;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.max_exp   = max_exp_r;
    assign bus.shift     = shift_r;
    assign bus.lane_en   = lane_en_r;
    assign bus.flush     = flush_r;
    assign bus.mode_out  = mode_out_r;
endmodule
